prog_loader: RTL and testbench



---
 rtl/prog_loader.sv | 157 +++++++++++++++
 tb/tb_prog_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program loader and boot sequencer: streams an image into memory while the core is held
// in reset, optionally verifies it by checksum readback, then releases the core with a start pulse.
module prog_loader #(
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int VERIFY        = 1,
    parameter int RELEASE_DELAY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [ADDR_WIDTH-1:0] load_len,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  own_bus,
    output logic                  core_reset_n,
    output logic                  trigger,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_VERIFY,
        S_RELEASE,
        S_RUN,
        S_ERROR
    } state_t;

    localparam int REL_W = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;

    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] base_q, len_q, cnt;
    logic [DATA_WIDTH-1:0] wr_sum, rd_sum;
    logic [REL_W-1:0]      rel_cnt;

    logic handshake, last_write, verify_end, sums_match;
    logic core_reset_n_d, own_bus_d, trigger_d, busy_d, done_d, error_d;

    assign last_write = handshake && (cnt == len_q - 1'b1);
    assign verify_end = (cnt == len_q);
    // The final readback word arrives in the last VERIFY cycle, so it is folded in here.
    assign sums_match = ((rd_sum + mem_dout) == wr_sum);

    // State register plus session datapath.
    // NOTE: every sequential assignment uses <= so all registers update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            base_q       <= '0;
            len_q        <= '0;
            cnt          <= '0;
            wr_sum       <= '0;
            rd_sum       <= '0;
            rel_cnt      <= '0;
            core_reset_n <= 1'b0;
            own_bus      <= 1'b1;
            trigger      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= next_state;
            core_reset_n <= core_reset_n_d;
            own_bus      <= own_bus_d;
            trigger      <= trigger_d;
            busy         <= busy_d;
            done         <= done_d;
            error        <= error_d;
            rel_cnt      <= (state == S_RELEASE) ? rel_cnt + 1'b1 : '0;

            case (state)
                S_IDLE, S_RUN, S_ERROR: begin
                    if (start) begin
                        base_q <= load_base;
                        len_q  <= load_len;
                        cnt    <= '0;
                        wr_sum <= '0;
                        rd_sum <= '0;
                    end
                end
                S_WRITE: begin
                    if (handshake) begin
                        wr_sum <= wr_sum + s_data;
                        cnt    <= last_write ? '0 : cnt + 1'b1;
                    end
                end
                S_VERIFY: begin
                    if (cnt != '0) begin
                        rd_sum <= rd_sum + mem_dout;
                    end
                    cnt <= verify_end ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic.
    // NOTE: next_state is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_RUN, S_ERROR: begin
                if (start) begin
                    next_state = (load_len != '0) ? S_WRITE : S_RELEASE;
                end
            end
            S_WRITE: begin
                if (last_write) begin
                    next_state = (VERIFY != 0) ? S_VERIFY : S_RELEASE;
                end
            end
            S_VERIFY: begin
                if (verify_end) begin
                    next_state = sums_match ? S_RELEASE : S_ERROR;
                end
            end
            S_RELEASE: begin
                if (rel_cnt == REL_W'(RELEASE_DELAY - 1)) begin
                    next_state = S_RUN;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Outputs: memory port is combinational; flags are computed from next_state and registered.
    always_comb begin
        s_ready   = (state == S_WRITE) && !reset;
        handshake = s_valid && s_ready;
        mem_we    = handshake;
        mem_din   = handshake ? s_data : '0;
        if (handshake || ((state == S_VERIFY) && !reset)) begin
            mem_addr = base_q + cnt;
        end else begin
            mem_addr = '0;
        end

        core_reset_n_d = (next_state == S_RUN);
        own_bus_d      = (next_state != S_RUN);
        done_d         = (next_state == S_RUN);
        trigger_d      = (next_state == S_RUN) && (state != S_RUN);
        error_d        = (next_state == S_ERROR);
        busy_d         = (next_state == S_WRITE) || (next_state == S_VERIFY) ||
                         (next_state == S_RELEASE);
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: behavioural memory, cycle-numbered session runner and
// hand-computed expectations for each boot scenario.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] load_base, load_len;
    logic        s_valid, s_ready;
    logic [7:0]  s_data;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din, mem_dout;
    logic        own_bus, core_reset_n, trigger, busy, done, error;

    logic        corrupt = 1'b0;
    logic        wipe    = 1'b0;
    logic [7:0]  mem [0:65535];

    int checks = 0;
    int errors = 0;

    logic [7:0] img [16] = '{8'hA9, 8'h04, 8'h85, 8'h02, 8'hA9, 8'h10, 8'hA9, 8'hFF,
                             8'h85, 8'h0C, 8'hA9, 8'h03, 8'h85, 8'h04, 8'h85, 8'h06};

    int   n_writes, first_we, last_we, addr_bad, we_no_valid;
    int   vfirst, vlast, busy_first, busy_last, rise_cycle, trig_cycle, trig_count, err_cycle;
    logic c1_crn, c1_done, c1_own, c1_busy;
    logic fin_err, fin_crn, fin_own, fin_done;
    int   we_in_reset = 0;

    prog_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .load_base    (load_base),
        .load_len     (load_len),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout),
        .own_bus      (own_bus),
        .core_reset_n (core_reset_n),
        .trigger      (trigger),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    // Shared memory model: synchronous write, one-cycle read latency.
    always @(posedge clk) begin
        if (wipe) begin
            for (int i = 0; i < 48; i++) mem[16'(i)] <= 8'h00;
            mem[16'hFFFE] <= 8'h00;
            mem[16'hFFFF] <= 8'h00;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_din;
            if (corrupt) mem[16'h001A] <= mem[16'h001A] ^ 8'hFF;
        end
        mem_dout <= mem[mem_addr];
        if (reset && mem_we) we_in_reset <= we_in_reset + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        wipe = 1'b1;
        @(posedge clk); #1;
        wipe = 1'b0;
        #2;
    endtask

    task automatic image_bad(input logic [15:0] base, output int n);
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (mem[base + 16'(i)] !== img[i]) n++;
        end
    endtask

    // Issues start, then runs max_cycles cycles numbered from 1 (cycle 1 follows the
    // edge that samples start), streaming the image and logging observed events.
    task automatic run_session(input logic [15:0] base, input logic [15:0] len,
                               input bit gaps, input bit corr, input int max_cycles);
        int si;
        si = 0;
        n_writes = 0; first_we = 0; last_we = 0; addr_bad = 0; we_no_valid = 0;
        vfirst = 0; vlast = 0; busy_first = 0; busy_last = 0;
        rise_cycle = 0; trig_cycle = 0; trig_count = 0; err_cycle = 0;
        start = 1'b1; load_base = base; load_len = len; s_valid = 1'b0;
        for (int k = 1; k <= max_cycles; k++) begin
            @(posedge clk); #1;
            start   = 1'b0;
            s_valid = gaps ? ((k % 2) == 1) : 1'b1;
            s_data  = img[si % 16];
            corrupt = corr && (k == int'(len) + 1);
            #2;
            if (k == 1) begin
                c1_crn = core_reset_n; c1_done = done; c1_own = own_bus; c1_busy = busy;
            end
            if (mem_we) begin
                n_writes++;
                if (first_we == 0) first_we = k;
                last_we = k;
                if (!s_valid) we_no_valid++;
                if (mem_addr !== base + 16'(si) || mem_din !== img[si % 16]) addr_bad++;
                si++;
            end
            if (busy && !s_ready && mem_addr != 16'h0000) begin
                if (vfirst == 0) vfirst = k;
                vlast = k;
            end
            if (busy) begin
                if (busy_first == 0) busy_first = k;
                busy_last = k;
            end
            if (core_reset_n === 1'b1 && rise_cycle == 0) rise_cycle = k;
            if (trigger) begin
                trig_count++;
                if (trig_cycle == 0) trig_cycle = k;
            end
            if (error && err_cycle == 0) err_cycle = k;
        end
        fin_err = error; fin_crn = core_reset_n; fin_own = own_bus; fin_done = done;
        s_valid = 1'b0;
        corrupt = 1'b0;
    endtask

    initial begin
        int bad;

        // Reset held with stream and start active.
        reset = 1'b1; start = 1'b1; s_valid = 1'b1; s_data = 8'h55;
        load_base = 16'h0018; load_len = 16'd16;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #3;
            check("rst_we", mem_we, 0);
            check("rst_ready", s_ready, 0);
            check("rst_addr", mem_addr, 0);
            check("rst_din", mem_din, 0);
            check("rst_core_reset_n", core_reset_n, 0);
            check("rst_own_bus", own_bus, 1);
            check("rst_flags", {trigger, busy, done, error}, 0);
        end
        check("rst_no_we_pulse", we_in_reset, 0);
        reset = 1'b0; start = 1'b0; s_valid = 1'b0;
        @(posedge clk); #3;
        check("idle_busy", busy, 0);
        check("idle_core_reset_n", core_reset_n, 0);

        // Gapless 16-word load at 0x18 with verify.
        clear_mem();
        run_session(16'h0018, 16'd16, 1'b0, 1'b0, 40);
        check("t1_writes", n_writes, 16);
        check("t1_first_we", first_we, 1);
        check("t1_last_we", last_we, 16);
        check("t1_addr_data", addr_bad, 0);
        check("t1_verify_first", vfirst, 17);
        check("t1_verify_last", vlast, 33);
        check("t1_busy_last", busy_last, 35);
        check("t1_rise", rise_cycle, 36);
        check("t1_trig_cycle", trig_cycle, 36);
        check("t1_trig_count", trig_count, 1);
        check("t1_run_flags", {fin_done, fin_own, fin_err}, 3'b100);
        image_bad(16'h0018, bad);
        check("t1_image", bad, 0);

        // Same image with s_valid toggling; restarted from RUN.
        clear_mem();
        run_session(16'h0018, 16'd16, 1'b1, 1'b0, 56);
        check("t2_writes", n_writes, 16);
        check("t2_first_we", first_we, 1);
        check("t2_last_we", last_we, 31);
        check("t2_we_without_valid", we_no_valid, 0);
        check("t2_addr_data", addr_bad, 0);
        check("t2_rise", rise_cycle, 51);
        image_bad(16'h0018, bad);
        check("t2_image", bad, 0);

        // Memory corrupted at 0x1A during VERIFY.
        run_session(16'h0018, 16'd16, 1'b0, 1'b1, 40);
        check("t3_err_cycle", err_cycle, 34);
        check("t3_no_rise", rise_cycle, 0);
        check("t3_no_trigger", trig_count, 0);
        check("t3_final", {fin_err, fin_crn, fin_own, fin_done}, 4'b1010);

        // Reload from ERROR succeeds.
        run_session(16'h0018, 16'd16, 1'b0, 1'b0, 40);
        check("t4_cycle1_error_cleared", c1_busy, 1);
        check("t4_rise", rise_cycle, 36);
        check("t4_trig_cycle", trig_cycle, 36);
        check("t4_error_final", fin_err, 0);
        image_bad(16'h0018, bad);
        check("t4_image", bad, 0);

        // Zero-length load.
        run_session(16'h0040, 16'd0, 1'b0, 1'b0, 8);
        check("t5_writes", n_writes, 0);
        check("t5_busy_first", busy_first, 1);
        check("t5_busy_last", busy_last, 2);
        check("t5_trig_cycle", trig_cycle, 3);
        check("t5_rise", rise_cycle, 3);

        // Address wrap at the top of memory.
        run_session(16'hFFFE, 16'd4, 1'b0, 1'b0, 16);
        check("t6_writes", n_writes, 4);
        check("t6_addr_data", addr_bad, 0);
        check("t6_mem_fffe", mem[16'hFFFE], 8'hA9);
        check("t6_mem_ffff", mem[16'hFFFF], 8'h04);
        check("t6_mem_0000", mem[16'h0000], 8'h85);
        check("t6_mem_0001", mem[16'h0001], 8'h02);
        check("t6_rise", rise_cycle, 12);

        // start in RUN drops the core back into reset on the next cycle and reloads.
        run_session(16'h0018, 16'd16, 1'b0, 1'b0, 40);
        check("t7_c1_core_reset_n", c1_crn, 0);
        check("t7_c1_done", c1_done, 0);
        check("t7_c1_own_bus", c1_own, 1);
        check("t7_c1_busy", c1_busy, 1);
        check("t7_writes", n_writes, 16);
        check("t7_rise", rise_cycle, 36);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
